// File: rtl/axi_dma_pkg.sv
// Shared AXI constants, request-channel FSM state type and AxSIZE helper for axi_dma_master.
package axi_dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [0:0] {IDLE, ISSUE} req_state_e;

    // AxSIZE encoding for a beat that fills the whole data bus.
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_dma_master_if.sv
// AXI4 memory port bundle between axi_dma_master (master) and the shell (slave).
interface axi_dma_master_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 512
);
    logic                    arvalid, arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    awvalid, awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    rvalid, rready, rlast;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    wvalid, wready, wlast;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid, bready;
    logic [1:0]              bresp;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, input arready,
        output awvalid, awaddr, awlen, awsize, awburst, input awready,
        input  rvalid, rdata, rresp, rlast, output rready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input  bvalid, bresp, output bready
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, output arready,
        input  awvalid, awaddr, awlen, awsize, awburst, output awready,
        output rvalid, rdata, rresp, rlast, input rready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bresp, input bready
    );
endinterface

// File: rtl/axi_dma_req_ch.sv
// One AXI address channel: IDLE/ISSUE request FSM plus outstanding-burst counter.
module axi_dma_req_ch
    import axi_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    output logic                  req_ack,
    output logic                  ax_valid,
    output logic [ADDR_WIDTH-1:0] ax_addr,
    output logic [7:0]            ax_len,
    input  logic                  ax_ready,
    input  logic                  retire,
    output logic                  retire_err
);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;

    req_state_e            state_q, state_d;
    logic [CntW-1:0]       out_q, out_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic                  issue, accept;

    assign issue    = (state_q == IDLE) && req && (out_q < CntW'(MAX_OUTSTANDING));
    assign accept   = (state_q == ISSUE) && ax_ready;
    assign req_ack  = accept;
    assign ax_valid = (state_q == ISSUE);
    assign ax_addr  = addr_q;
    assign ax_len   = len_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (issue)    state_d = ISSUE;
            ISSUE: if (ax_ready) state_d = IDLE;
        endcase
    end

    // A retire with nothing outstanding is dropped and reported upstream.
    always_comb begin
        out_d      = out_q;
        retire_err = 1'b0;
        if (accept && !retire) begin
            out_d = out_q + 1'b1;
        end else if (retire && !accept) begin
            if (out_q == '0) retire_err = 1'b1;
            else             out_d      = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            if (issue) begin
                addr_q <= addr;
                len_q  <= len;
            end
        end
    end

endmodule

// File: rtl/axi_dma_master.sv
// Turns decompressor dma_rd_*/dma_wr_* requests into AXI4 bursts with W gated behind AW.
// Optional AXI_DMA_LAST_GEN_EN: generate wlast from the issued AW lengths and flag mismatches.
module axi_dma_master
    import axi_dma_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned MAX_OUTSTANDING    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            dma_rd_req,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   dma_rd_addr,
    input  logic [7:0]                      dma_rd_len,
    output logic                            dma_rd_req_ack,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   dma_rd_data,
    output logic                            dma_rd_data_valid,
    input  logic                            dma_rd_data_taken,
    input  logic                            dma_wr_req,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   dma_wr_addr,
    input  logic [7:0]                      dma_wr_len,
    output logic                            dma_wr_req_ack,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   dma_wr_data,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] dma_wr_strobe,
    input  logic                            dma_wr_wvalid,
    input  logic                            dma_wr_data_last,
    output logic                            dma_wr_ready,
    input  logic                            dma_wr_bready,
    output logic                            dma_wr_done,
    input  logic                            err_clr,
    output logic                            rd_err,
    output logic                            wr_err,
    axi_dma_master_if.master                m_axi
);
    localparam logic [2:0]  AXI_SIZE = axi_size(C_M_AXI_DATA_WIDTH);
    localparam int unsigned CntW     = $clog2(MAX_OUTSTANDING) + 1;

    logic            r_hs, rlast_hs, aw_hs, w_hs, wlast_hs, b_hs;
    logic            rd_cnt_err, wr_cnt_err, last_err, w_open;
    logic [CntW-1:0] w_credit_q, w_credit_d;
    logic            rd_err_q, wr_err_q;

    axi_dma_req_ch #(
        .ADDR_WIDTH      (C_M_AXI_ADDR_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_ar_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (dma_rd_req),
        .addr       (dma_rd_addr),
        .len        (dma_rd_len),
        .req_ack    (dma_rd_req_ack),
        .ax_valid   (m_axi.arvalid),
        .ax_addr    (m_axi.araddr),
        .ax_len     (m_axi.arlen),
        .ax_ready   (m_axi.arready),
        .retire     (rlast_hs),
        .retire_err (rd_cnt_err)
    );

    axi_dma_req_ch #(
        .ADDR_WIDTH      (C_M_AXI_ADDR_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_aw_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (dma_wr_req),
        .addr       (dma_wr_addr),
        .len        (dma_wr_len),
        .req_ack    (dma_wr_req_ack),
        .ax_valid   (m_axi.awvalid),
        .ax_addr    (m_axi.awaddr),
        .ax_len     (m_axi.awlen),
        .ax_ready   (m_axi.awready),
        .retire     (b_hs),
        .retire_err (wr_cnt_err)
    );

    assign m_axi.arsize  = AXI_SIZE;
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.awsize  = AXI_SIZE;
    assign m_axi.awburst = AXI_BURST_INCR;

    assign m_axi.rready      = dma_rd_data_taken;
    assign dma_rd_data       = m_axi.rdata;
    assign dma_rd_data_valid = m_axi.rvalid & dma_rd_data_taken;
    assign r_hs              = m_axi.rvalid & m_axi.rready;
    assign rlast_hs          = r_hs & m_axi.rlast;

    // W beats only flow while at least one accepted AW still owes its data.
    assign w_open       = (w_credit_q != '0);
    assign m_axi.wvalid = dma_wr_wvalid & w_open;
    assign m_axi.wdata  = dma_wr_data;
    assign m_axi.wstrb  = dma_wr_strobe;
    assign dma_wr_ready = m_axi.wready & w_open;
    assign aw_hs        = m_axi.awvalid & m_axi.awready;
    assign w_hs         = m_axi.wvalid & m_axi.wready;
    assign wlast_hs     = w_hs & m_axi.wlast;

    assign m_axi.bready = dma_wr_bready;
    assign b_hs         = m_axi.bvalid & m_axi.bready;
    assign dma_wr_done  = b_hs;

    always_comb begin
        w_credit_d = w_credit_q;
        if (aw_hs && !wlast_hs)      w_credit_d = w_credit_q + 1'b1;
        else if (wlast_hs && !aw_hs) w_credit_d = w_credit_q - 1'b1;
    end

`ifdef AXI_DMA_LAST_GEN_EN
    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);

    logic [7:0]      len_fifo_q [MAX_OUTSTANDING];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]      beat_q;

    assign m_axi.wlast = w_open && (beat_q == len_fifo_q[rd_ptr_q]);
    assign last_err    = w_hs && (dma_wr_data_last != m_axi.wlast);

    always_ff @(posedge clk) begin
        if (aw_hs) len_fifo_q[wr_ptr_q] <= m_axi.awlen;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            if (aw_hs) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (wlast_hs) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                beat_q   <= '0;
            end else if (w_hs) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end
`else
    assign m_axi.wlast = dma_wr_data_last;
    assign last_err    = 1'b0;
`endif

    assign rd_err = rd_err_q;
    assign wr_err = wr_err_q;

    // A new error in the same cycle as err_clr survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_credit_q <= '0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            w_credit_q <= w_credit_d;
            if ((r_hs && (m_axi.rresp != AXI_RESP_OKAY)) || rd_cnt_err) rd_err_q <= 1'b1;
            else if (err_clr)                                          rd_err_q <= 1'b0;
            if ((b_hs && (m_axi.bresp != AXI_RESP_OKAY)) || wr_cnt_err || last_err) begin
                wr_err_q <= 1'b1;
            end else if (err_clr) begin
                wr_err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_dma_master.sv
// Randomized bench for axi_dma_master: a bench-side AXI slave and requester, checked against
// a transaction-level model of outstanding bursts and sticky error flags.
module tb_axi_dma_master;

    localparam int unsigned AW   = 64;
    localparam int unsigned DW   = 64;
    localparam int unsigned MAXO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            dma_rd_req, dma_rd_req_ack, dma_rd_data_valid, dma_rd_data_taken;
    logic [AW-1:0]   dma_rd_addr, dma_wr_addr;
    logic [7:0]      dma_rd_len, dma_wr_len;
    logic [DW-1:0]   dma_rd_data, dma_wr_data;
    logic [DW/8-1:0] dma_wr_strobe;
    logic            dma_wr_req, dma_wr_req_ack, dma_wr_wvalid, dma_wr_data_last;
    logic            dma_wr_ready, dma_wr_bready, dma_wr_done;
    logic            err_clr, rd_err, wr_err;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   err_pct = 0;
    int   exp_rd_out = 0;
    int   exp_wr_out = 0;
    logic exp_rd_err = 1'b0;
    logic exp_wr_err = 1'b0;

    axi_dma_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi ();

    axi_dma_master #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .MAX_OUTSTANDING    (MAXO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dma_rd_req        (dma_rd_req),
        .dma_rd_addr       (dma_rd_addr),
        .dma_rd_len        (dma_rd_len),
        .dma_rd_req_ack    (dma_rd_req_ack),
        .dma_rd_data       (dma_rd_data),
        .dma_rd_data_valid (dma_rd_data_valid),
        .dma_rd_data_taken (dma_rd_data_taken),
        .dma_wr_req        (dma_wr_req),
        .dma_wr_addr       (dma_wr_addr),
        .dma_wr_len        (dma_wr_len),
        .dma_wr_req_ack    (dma_wr_req_ack),
        .dma_wr_data       (dma_wr_data),
        .dma_wr_strobe     (dma_wr_strobe),
        .dma_wr_wvalid     (dma_wr_wvalid),
        .dma_wr_data_last  (dma_wr_data_last),
        .dma_wr_ready      (dma_wr_ready),
        .dma_wr_bready     (dma_wr_bready),
        .dma_wr_done       (dma_wr_done),
        .err_clr           (err_clr),
        .rd_err            (rd_err),
        .wr_err            (wr_err),
        .m_axi             (m_axi)
    );

    always @(posedge clk) if (rst_n && dma_wr_done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] pick_resp();
        if ($urandom_range(99) < err_pct) return 2'($urandom_range(3, 1));
        return 2'b00;
    endfunction

    // Request one burst on AR (wr=0) or AW (wr=1); ready is raised after 'delay' valid cycles.
    task automatic issue_req(input bit wr, input logic [AW-1:0] addr, input logic [7:0] len,
                             input int delay);
        int    n = 0;
        string p = wr ? "aw" : "ar";
        logic  vld;
        @(negedge clk);
        if (wr) begin dma_wr_req = 1'b1; dma_wr_addr = addr; dma_wr_len = len; end
        else    begin dma_rd_req = 1'b1; dma_rd_addr = addr; dma_rd_len = len; end
        do begin
            @(negedge clk);
            n++;
            if (wr) check("w_gated", 64'(m_axi.wvalid), 64'd0);
            vld = wr ? m_axi.awvalid : m_axi.arvalid;
        end while (!vld && n < 16);
        check({p, "_valid"}, 64'(vld), 64'd1);
        check({p, "_addr"}, wr ? m_axi.awaddr : m_axi.araddr, addr);
        check({p, "_len"}, 64'(wr ? m_axi.awlen : m_axi.arlen), 64'(len));
        check({p, "_ack_early"}, 64'(wr ? dma_wr_req_ack : dma_rd_req_ack), 64'd0);
        repeat (delay) @(negedge clk);
        if (wr) m_axi.awready = 1'b1; else m_axi.arready = 1'b1;
        #1;
        check({p, "_ack"}, 64'(wr ? dma_wr_req_ack : dma_rd_req_ack), 64'd1);
        if (wr) exp_wr_out++; else exp_rd_out++;
        @(negedge clk);
        if (wr) begin m_axi.awready = 1'b0; dma_wr_req = 1'b0; end
        else    begin m_axi.arready = 1'b0; dma_rd_req = 1'b0; end
        #1;
        check({p, "_ack_pulse"}, 64'(wr ? dma_wr_req_ack : dma_rd_req_ack), 64'd0);
        check({p, "_valid_drop"}, 64'(wr ? m_axi.awvalid : m_axi.arvalid), 64'd0);
    endtask

    // Deliver len+1 R beats; the consumer stalls with probability stall_pct.
    task automatic read_beats(input logic [7:0] len, input int stall_pct);
        int          i = 0;
        int          n = 0;
        logic [DW-1:0] d = {$urandom, $urandom};
        logic [1:0]  resp = pick_resp();
        while (i <= int'(len) && n < 200) begin
            @(negedge clk);
            n++;
            m_axi.rvalid = 1'b1; m_axi.rdata = d; m_axi.rresp = resp;
            m_axi.rlast = (i == int'(len));
            dma_rd_data_taken = ($urandom_range(99) >= stall_pct);
            #1;
            check("rready", 64'(m_axi.rready), 64'(dma_rd_data_taken));
            check("rd_valid", 64'(dma_rd_data_valid), 64'(dma_rd_data_taken));
            check("rd_data", dma_rd_data, d);
            if (dma_rd_data_taken) begin
                if (resp != 2'b00) exp_rd_err = 1'b1;
                if (i == int'(len)) begin
                    if (exp_rd_out == 0) exp_rd_err = 1'b1; else exp_rd_out--;
                end
                i++;
                d = {$urandom, $urandom};
                resp = pick_resp();
            end
        end
        check("rd_beats", 64'(i), 64'(len) + 64'd1);
        @(negedge clk);
        m_axi.rvalid = 1'b0; m_axi.rlast = 1'b0; dma_rd_data_taken = 1'b0;
    endtask

    // Offer len+1 W beats with random gaps; early_last raises data_last on beat 0 instead.
    task automatic write_beats(input logic [7:0] len, input int stall_pct, input bit early_last);
        int              i = 0;
        int              n = 0;
        logic [DW-1:0]   d = {$urandom, $urandom};
        logic [DW/8-1:0] s = 8'($urandom);
        while (i <= int'(len) && n < 200) begin
            @(negedge clk);
            n++;
            dma_wr_wvalid = ($urandom_range(99) >= stall_pct);
            dma_wr_data = d; dma_wr_strobe = s;
            dma_wr_data_last = early_last ? (i == 0) : (i == int'(len));
            m_axi.wready = ($urandom_range(99) >= stall_pct);
            #1;
            check("wvalid", 64'(m_axi.wvalid), 64'(dma_wr_wvalid));
            check("wr_ready", 64'(dma_wr_ready), 64'(m_axi.wready));
            if (dma_wr_wvalid) begin
                check("wdata", m_axi.wdata, d);
                check("wstrb", 64'(m_axi.wstrb), 64'(s));
                check("wlast", 64'(m_axi.wlast), 64'(i == int'(len)));
            end
            if (dma_wr_wvalid && m_axi.wready) begin
`ifdef AXI_DMA_LAST_GEN_EN
                if (dma_wr_data_last != (i == int'(len))) exp_wr_err = 1'b1;
`endif
                i++;
                d = {$urandom, $urandom};
                s = 8'($urandom);
            end
        end
        check("wr_beats", 64'(i), 64'(len) + 64'd1);
        @(negedge clk);
        dma_wr_wvalid = 1'b0; dma_wr_data_last = 1'b0; m_axi.wready = 1'b0;
    endtask

    // Present one B response; clr drives err_clr in the handshake cycle.
    task automatic do_b(input logic [1:0] resp, input bit clr);
        int n = 0;
        while (1) begin
            @(negedge clk);
            m_axi.bvalid = 1'b1; m_axi.bresp = resp; err_clr = clr;
            dma_wr_bready = (clr || n >= 7) ? 1'b1 : 1'($urandom_range(1));
            #1;
            check("wr_done", 64'(dma_wr_done), 64'(dma_wr_bready));
            if (err_clr) begin exp_rd_err = 1'b0; exp_wr_err = 1'b0; end
            n++;
            if (dma_wr_bready) begin
                if (resp != 2'b00) exp_wr_err = 1'b1;
                if (exp_wr_out == 0) exp_wr_err = 1'b1; else exp_wr_out--;
                break;
            end
        end
        @(negedge clk);
        m_axi.bvalid = 1'b0; dma_wr_bready = 1'b0; err_clr = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        exp_rd_err = 1'b0; exp_wr_err = 1'b0;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("rd_err_clr", 64'(rd_err), 64'(exp_rd_err));
        check("wr_err_clr", 64'(wr_err), 64'(exp_wr_err));
    endtask

    task automatic check_state(input string tag);
        check({tag, "_rd_err"}, 64'(rd_err), 64'(exp_rd_err));
        check({tag, "_wr_err"}, 64'(wr_err), 64'(exp_wr_err));
        check({tag, "_rd_out"}, 64'(dut.u_ar_ch.out_q), 64'(exp_rd_out));
        check({tag, "_wr_out"}, 64'(dut.u_aw_ch.out_q), 64'(exp_wr_out));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            done0;
        logic [AW-1:0] a;
        logic [7:0]    l;
        dma_rd_req = 0; dma_rd_addr = '0; dma_rd_len = '0; dma_rd_data_taken = 0;
        dma_wr_req = 0; dma_wr_addr = '0; dma_wr_len = '0; dma_wr_data = '0;
        dma_wr_strobe = '0; dma_wr_wvalid = 0; dma_wr_data_last = 0; dma_wr_bready = 0;
        err_clr = 0;
        m_axi.arready = 0; m_axi.awready = 0; m_axi.wready = 0;
        m_axi.rvalid = 0; m_axi.rdata = '0; m_axi.rresp = '0; m_axi.rlast = 0;
        m_axi.bvalid = 0; m_axi.bresp = '0;

        #22;
        check("rst_arvalid", 64'(m_axi.arvalid), 64'd0);
        check("rst_awvalid", 64'(m_axi.awvalid), 64'd0);
        check("rst_wvalid", 64'(m_axi.wvalid), 64'd0);
        check("rst_errs", {62'd0, rd_err, wr_err}, 64'd0);
        check("rst_acks", {61'd0, dma_rd_req_ack, dma_wr_req_ack, dma_wr_done}, 64'd0);
        check("arsize", 64'(m_axi.arsize), 64'd3);
        check("awsize", 64'(m_axi.awsize), 64'd3);
        check("arburst", 64'(m_axi.arburst), 64'd1);
        check("awburst", 64'(m_axi.awburst), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single read burst, then a read with consumer back-pressure.
        issue_req(0, 64'h1000, 8'd3, 2);
        read_beats(8'd3, 0);
        check_state("t1");
        issue_req(0, 64'h2040, 8'd3, 0);
        read_beats(8'd3, 60);
        check_state("t2");

        // Write data offered before any AW is accepted must be held back.
        @(negedge clk);
        dma_wr_wvalid = 1'b1; dma_wr_data_last = 1'b0; m_axi.wready = 1'b1;
        repeat (3) begin
            #1;
            check("w_pre_aw", 64'(m_axi.wvalid), 64'd0);
            check("wr_ready_pre_aw", 64'(dma_wr_ready), 64'd0);
            @(negedge clk);
        end
        issue_req(1, 64'h3000, 8'd3, 1);
        write_beats(8'd3, 0, 0);
        do_b(2'b00, 0);
        check_state("t3");

        // Outstanding write limit: the fifth AW waits for the first B.
        done0 = done_cnt;
        for (int k = 0; k < 4; k++) begin
            issue_req(1, 64'h4000 + 64'(k * 64), 8'd0, 0);
            write_beats(8'd0, 0, 0);
        end
        @(negedge clk);
        dma_wr_req = 1'b1; dma_wr_addr = 64'h4100; dma_wr_len = 8'd0;
        repeat (5) begin
            @(negedge clk);
            check("aw_blocked", 64'(m_axi.awvalid), 64'd0);
        end
        do_b(2'b00, 0);
        issue_req(1, 64'h4100, 8'd0, 0);
        write_beats(8'd0, 0, 0);
        repeat (4) do_b(2'b00, 0);
        check("done_pulses", 64'(done_cnt - done0), 64'd5);
        check_state("t4");

        // Sticky write error, and set beating a same-cycle clear.
        for (int k = 0; k < 2; k++) begin
            issue_req(1, 64'h6000, 8'd1, 0);
            write_beats(8'd1, 0, 0);
            do_b(k == 1 ? 2'b10 : 2'b00, 0);
        end
        check("wr_err_set", 64'(wr_err), 64'd1);
        repeat (3) @(negedge clk);
        check("wr_err_hold", 64'(wr_err), 64'd1);
        issue_req(1, 64'h6100, 8'd0, 0);
        write_beats(8'd0, 0, 0);
        do_b(2'b11, 1);
        check("wr_err_set_wins", 64'(wr_err), 64'd1);
        check_state("t5");
        clear_err();

        // Retire with nothing outstanding is ignored but flagged.
        do_b(2'b00, 0);
        check_state("spur_b");
        read_beats(8'd0, 0);
        check_state("spur_r");
        clear_err();

`ifdef AXI_DMA_LAST_GEN_EN
        issue_req(1, 64'h5000, 8'd1, 0);
        write_beats(8'd1, 0, 1);
        do_b(2'b00, 0);
        check("last_mismatch_err", 64'(wr_err), 64'd1);
        check_state("t6");
        clear_err();
`endif

        err_pct = 15;
        for (int it = 0; it < 30; it++) begin
            a = {32'd0, $urandom} & ~64'h7;
            l = 8'($urandom_range(3));
            if ($urandom_range(1) == 1) begin
                issue_req(0, a, l, $urandom_range(2));
                read_beats(l, 30);
            end else begin
                issue_req(1, a, l, $urandom_range(2));
                write_beats(l, 30, 0);
                do_b(pick_resp(), $urandom_range(9) == 0);
            end
            check_state("rand");
            if ($urandom_range(4) == 0) clear_err();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
